pill_schedule_sequencer: RTL and testbench
==========================================

PILL_SCHEDULE_SEQUENCER -- requirements
Module: pill_schedule_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: clk cycles per one-second tick.
REQ-002 SHALL have parameter ROM_AW, default 5: schedule ROM address width.
REQ-003 SHALL have parameter ALARM_TIMEOUT_S, default 30: seconds allowed for ack before a dose is missed.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins the schedule at address 0.
REQ-007 SHALL have port ack, input, 1: user acknowledge of the alarm.
REQ-008 SHALL have port snooze, input, 1: user snooze request (see Configuration).
REQ-009 SHALL have port rom_addr, output, ROM_AW: schedule ROM address.
REQ-010 SHALL have port rom_data, input, 28: ROM word, valid one cycle after rom_addr.
REQ-011 SHALL have port rom_content, output, 28: latched current entry for the LCD.
REQ-012 SHALL have port pill12_and3_duration, output, 12: remaining dispense seconds {pill1[11:8], pill2[7:4], pill3[3:0]}.
REQ-013 SHALL have port dispense, output, 3: per-pill dispense enables, bit0 = pill1.
REQ-014 SHALL have ports alarm, done (1 bit each) and missed_count (output, 4): alarm active, schedule finished, saturating count of missed doses.

Function
REQ-015 SHALL decode each ROM entry as: [27] end marker; [26:24] pill mask; [23:12] interval in seconds; [11:0] three 4-bit durations, in the same order as pill12_and3_duration.
REQ-016 SHALL implement FSM states IDLE, FETCH, LOAD, WAIT_INT, ALARM, DISPENSE, NEXT, DONE.
REQ-017 IDLE: on start -> FETCH with rom_addr=0.
REQ-018 FETCH: hold rom_addr for one cycle -> LOAD.
REQ-019 LOAD: sample rom_data. End marker set -> DONE, with rom_content unchanged. Otherwise latch rom_content, load interval counter, -> WAIT_INT, or -> ALARM if interval=0.
REQ-020 WAIT_INT: decrement the interval on each tick; the tick that takes it from 1 to 0 moves to ALARM on the next cycle.
REQ-021 ALARM: alarm=1.
- ack -> DISPENSE, loading each duration counter with its duration field if its mask bit is set, else 0.
- ALARM_TIMEOUT_S ticks without ack -> missed_count+1 (saturates at 15) -> NEXT.
- ack and timeout tick in the same cycle: ack wins.
REQ-022 DISPENSE: dispense[i]=1 exactly while counter i is nonzero; each nonzero counter decrements on tick; all counters zero -> NEXT. If all counters load zero, DISPENSE lasts one cycle.
REQ-023 NEXT: rom_addr increments, wrapping from 2^ROM_AW-1 to 0 -> FETCH.
REQ-024 DONE: done=1; start -> FETCH at address 0 with missed_count cleared; otherwise hold.
REQ-025 SHALL ignore start in all states except IDLE and DONE; SHALL ignore ack outside ALARM.
REQ-026 tick SHALL be a one-cycle pulse every CLK_HZ clk cycles, free-running from reset.

Reset
REQ-027 While reset=1 the block SHALL go to IDLE and clear every output and counter to 0, including the prescaler; this applies mid-operation in any state.
REQ-028 The first start SHALL be accepted on the first cycle after reset deasserts.

Configuration
REQ-029 With PILL_SEQ_SNOOZE_EN defined: snooze in ALARM (ack not asserted) SHALL drop alarm, load a 60-second snooze counter, return to ALARM when it expires, and restart the timeout count.
REQ-030 With PILL_SEQ_SNOOZE_EN defined, ack SHALL take priority over snooze.
REQ-031 Without PILL_SEQ_SNOOZE_EN: the snooze port SHALL remain present but be ignored; no snooze logic is built.

Structure
REQ-032 Package pill_pkg SHALL hold the FSM state enum, the entry field bit positions, SNOOZE_S=60 and the missed-count width.
REQ-033 The one-second prescaler SHALL be the sub-module sec_tick_gen (clk, reset, tick; parameter CLK_HZ).

Verification
REQ-034 CLK_HZ=4, entry 0 = 0x7002_123 (mask 111, interval 2, durations 1/2/3): after start, alarm rises after 2 ticks; ack -> dispense=111, then 110 and 100, then 000 at ticks 1/2/3; pill12_and3_duration goes 0x123 -> 0x012 -> 0x001 -> 0x000.
REQ-035 Entry with interval 0 and no ack for 30 ticks -> missed_count=1, rom_addr advances, dispense never asserted.
REQ-036 Entry 1 = 0x8000000 -> done=1 after LOAD, rom_content keeps entry 0; a second start re-fetches address 0 with missed_count=0.
REQ-037 ROM_AW=2 with no end marker -> rom_addr sequence 0,1,2,3,0.
REQ-038 reset asserted during DISPENSE -> next cycle all outputs 0, state IDLE; ack and timeout tick in the same cycle -> DISPENSE with missed_count unchanged.
REQ-039 With PILL_SEQ_SNOOZE_EN: snooze in ALARM -> alarm=0 for 60 ticks, then alarm=1 again; without the macro, snooze has no effect.

Source files
------------

// File: rtl/pill_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pill_pkg
// Brief    : Shared types, schedule-entry field positions and helpers for
//            the pill schedule sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pill_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    LOAD     = 3'd2,
    WAIT_INT = 3'd3,
    ALARM    = 3'd4,
    DISPENSE = 3'd5,
    NEXT     = 3'd6,
    DONE     = 3'd7
  } state_e;

  // Schedule ROM entry layout
  localparam int ENTRY_W  = 28;
  localparam int END_BIT  = 27;
  localparam int MASK_HI  = 26;
  localparam int MASK_LO  = 24;
  localparam int INT_HI   = 23;
  localparam int INT_LO   = 12;
  localparam int DUR_HI   = 11;
  localparam int DUR_LO   = 0;

  localparam int SNOOZE_S = 60;
  localparam int MISSED_W = 4;

  // Zero each pill's duration whose mask bit is clear; mask[0] is pill1 = dur[11:8]
  function automatic logic [11:0] mask_durations(input logic [2:0] mask,
                                                 input logic [11:0] dur);
    logic [11:0] r;
    r[11:8] = mask[0] ? dur[11:8] : 4'd0;
    r[7:4]  = mask[1] ? dur[7:4]  : 4'd0;
    r[3:0]  = mask[2] ? dur[3:0]  : 4'd0;
    return r;
  endfunction

  // One-second step of every still-running duration counter
  function automatic logic [11:0] dec_durations(input logic [11:0] dur);
    logic [11:0] r;
    r[11:8] = (dur[11:8] != 4'd0) ? dur[11:8] - 4'd1 : 4'd0;
    r[7:4]  = (dur[7:4]  != 4'd0) ? dur[7:4]  - 4'd1 : 4'd0;
    r[3:0]  = (dur[3:0]  != 4'd0) ? dur[3:0]  - 4'd1 : 4'd0;
    return r;
  endfunction

  // Dispense enables, bit0 = pill1
  function automatic logic [2:0] active_pills(input logic [11:0] dur);
    return {dur[3:0] != 4'd0, dur[7:4] != 4'd0, dur[11:8] != 4'd0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sec_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : sec_tick_gen
// Brief    : Free-running prescaler producing a one-cycle tick every CLK_HZ
//            clock cycles, restarted by reset.
// Revision : 1.0 - initial release
// ============================================================================
module sec_tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count 0..CLK_HZ-1 and wrap
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == C_LAST) cnt_d = '0;
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Masked by reset so the tick stays low even when CLK_HZ is 1
  assign tick = (cnt_q == C_LAST) && !reset;

endmodule
`default_nettype wire

// File: rtl/pill_schedule_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pill_schedule_sequencer
// Brief    : Walks a schedule ROM, waits each entry's interval, raises an
//            alarm, dispenses the masked pills on ack and counts missed doses.
//            Optional snooze support: define PILL_SEQ_SNOOZE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pill_schedule_sequencer
  import pill_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int ROM_AW          = 5,
  parameter int ALARM_TIMEOUT_S = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                ack,
  input  logic                snooze,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [ENTRY_W-1:0]  rom_data,
  output logic [ENTRY_W-1:0]  rom_content,
  output logic [11:0]         pill12_and3_duration,
  output logic [2:0]          dispense,
  output logic                alarm,
  output logic                done,
  output logic [MISSED_W-1:0] missed_count
);

  localparam int TW = (ALARM_TIMEOUT_S > 1) ? $clog2(ALARM_TIMEOUT_S + 1) : 1;
  localparam logic [TW-1:0] C_TO_LAST = TW'(ALARM_TIMEOUT_S - 1);

  logic tick;

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  state_e                state_q,       state_d;
  logic [ROM_AW-1:0]     rom_addr_q,    rom_addr_d;
  logic [ENTRY_W-1:0]    rom_content_q, rom_content_d;
  logic [11:0]           int_cnt_q,     int_cnt_d;
  logic [11:0]           dur_q,         dur_d;
  logic [TW-1:0]         to_cnt_q,      to_cnt_d;
  logic [MISSED_W-1:0]   missed_q,      missed_d;
  logic                  alarm_q,       alarm_d;
  logic                  done_q,        done_d;
  logic [2:0]            dispense_q,    dispense_d;
  logic                  snoozing;

`ifdef PILL_SEQ_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_S + 1);
  logic                  snoozing_q,    snoozing_d;
  logic [SW-1:0]         snz_cnt_q,     snz_cnt_d;
  assign snoozing = snoozing_d;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snoozing      = 1'b0;
`endif

  // Next-state and datapath decisions for the schedule walker
  always_comb begin
    state_d       = state_q;
    rom_addr_d    = rom_addr_q;
    rom_content_d = rom_content_q;
    int_cnt_d     = int_cnt_q;
    dur_d         = dur_q;
    to_cnt_d      = to_cnt_q;
    missed_d      = missed_q;
`ifdef PILL_SEQ_SNOOZE_EN
    snoozing_d    = snoozing_q;
    snz_cnt_d     = snz_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          rom_addr_d = '0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        if (rom_data[END_BIT]) begin
          state_d = DONE;
        end else begin
          rom_content_d = rom_data;
          int_cnt_d     = rom_data[INT_HI:INT_LO];
          to_cnt_d      = '0;
          state_d       = (rom_data[INT_HI:INT_LO] == 12'd0) ? ALARM : WAIT_INT;
        end
      end
      WAIT_INT: begin
        if (tick) begin
          int_cnt_d = int_cnt_q - 12'd1;
          if (int_cnt_q == 12'd1) begin
            state_d  = ALARM;
            to_cnt_d = '0;
          end
        end
      end
      ALARM: begin
        // ack outranks both a timeout on the same tick and a snooze request
        if (ack) begin
          dur_d   = mask_durations(rom_content_q[MASK_HI:MASK_LO],
                                   rom_content_q[DUR_HI:DUR_LO]);
          state_d = DISPENSE;
`ifdef PILL_SEQ_SNOOZE_EN
          snoozing_d = 1'b0;
        end else if (snoozing_q) begin
          if (tick) begin
            snz_cnt_d = snz_cnt_q - 1'b1;
            if (snz_cnt_q == SW'(1)) begin
              snoozing_d = 1'b0;
              to_cnt_d   = '0;
            end
          end
        end else if (snooze) begin
          snoozing_d = 1'b1;
          snz_cnt_d  = SW'(SNOOZE_S);
          to_cnt_d   = '0;
`endif
        end else if (tick) begin
          if (to_cnt_q == C_TO_LAST) begin
            to_cnt_d = '0;
            if (missed_q != '1) missed_d = missed_q + 1'b1;
            state_d  = NEXT;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      DISPENSE: begin
        if (dur_q == 12'd0)  state_d = NEXT;
        else if (tick)       dur_d   = dec_durations(dur_q);
      end
      NEXT: begin
        rom_addr_d = rom_addr_q + 1'b1;
        state_d    = FETCH;
      end
      DONE: begin
        if (start) begin
          state_d    = FETCH;
          rom_addr_d = '0;
          missed_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    alarm_d    = (state_d == ALARM) && !snoozing;
    done_d     = (state_d == DONE);
    dispense_d = active_pills(dur_d);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rom_addr_q    <= '0;
      rom_content_q <= '0;
      int_cnt_q     <= '0;
      dur_q         <= '0;
      to_cnt_q      <= '0;
      missed_q      <= '0;
      alarm_q       <= 1'b0;
      done_q        <= 1'b0;
      dispense_q    <= '0;
`ifdef PILL_SEQ_SNOOZE_EN
      snoozing_q    <= 1'b0;
      snz_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      rom_content_q <= rom_content_d;
      int_cnt_q     <= int_cnt_d;
      dur_q         <= dur_d;
      to_cnt_q      <= to_cnt_d;
      missed_q      <= missed_d;
      alarm_q       <= alarm_d;
      done_q        <= done_d;
      dispense_q    <= dispense_d;
`ifdef PILL_SEQ_SNOOZE_EN
      snoozing_q    <= snoozing_d;
      snz_cnt_q     <= snz_cnt_d;
`endif
    end
  end

  assign rom_addr             = rom_addr_q;
  assign rom_content          = rom_content_q;
  assign pill12_and3_duration = dur_q;
  assign dispense             = dispense_q;
  assign alarm                = alarm_q;
  assign done                 = done_q;
  assign missed_count         = missed_q;

endmodule
`default_nettype wire

// File: tb/tb_pill_schedule_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pill_schedule_sequencer
// Brief    : Directed scoreboard bench for pill_schedule_sequencer
//            (CLK_HZ=4, ROM_AW=2, default build without snooze).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pill_schedule_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, ack, snooze;
  logic [1:0]  rom_addr;
  logic [27:0] rom_data = '0;
  logic [27:0] rom_content;
  logic [11:0] dur;
  logic [2:0]  dispense;
  logic        alarm, done;
  logic [3:0]  missed_count;

  logic [27:0] rom [4];

  int gcnt = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]  addr;
    logic [27:0] content;
    logic        alarm;
    logic [2:0]  disp;
    logic [11:0] dur;
    logic        done;
    logic [3:0]  missed;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t exp_q[$];

  pill_schedule_sequencer #(
    .CLK_HZ(4), .ROM_AW(2), .ALARM_TIMEOUT_S(30)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .ack                  (ack),
    .snooze               (snooze),
    .rom_addr             (rom_addr),
    .rom_data             (rom_data),
    .rom_content          (rom_content),
    .pill12_and3_duration (dur),
    .dispense             (dispense),
    .alarm                (alarm),
    .done                 (done),
    .missed_count         (missed_count)
  );

  always #5 clk = ~clk;

  // Edge counter and registered ROM (data valid one cycle after address)
  always @(posedge clk) begin
    gcnt     <= gcnt + 1;
    rom_data <= rom[rom_addr];
  end

  task automatic push(input int cyc, input logic [1:0] a, input logic [27:0] c,
                      input logic al, input logic [2:0] d, input logic [11:0] du,
                      input logic dn, input logic [3:0] m);
    exp_t e;
    e.cyc = cyc;
    e.o   = '{addr: a, content: c, alarm: al, disp: d, dur: du, done: dn, missed: m};
    exp_q.push_back(e);
  endtask

  // Drive so the value is seen by posedge number g
  task automatic at(input int g);
    while (gcnt < g - 1) @(negedge clk);
    #1;
  endtask

  // Monitor: every change of the visible outputs is one presented vector
  initial begin
    obs_t cur, prev;
    exp_t e;
    bit   have_prev;
    have_prev = 1'b0;
    prev      = '0;
    forever begin
      @(negedge clk);
      cur = '{addr: rom_addr, content: rom_content, alarm: alarm, disp: dispense,
              dur: dur, done: done, missed: missed_count};
      if (!have_prev || cur !== prev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output cyc=%0d actual=%h required=none", gcnt, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != gcnt || e.o !== cur) begin
            n_err++;
            $display("FAIL vector cyc=%0d actual=%h required cyc=%0d value=%h",
                     gcnt, cur, e.cyc, e.o);
          end
        end
      end
      prev      = cur;
      have_prev = 1'b1;
    end
  end

  // Stimulus with hand-derived expectations (ticks land on edges 7,11,15,...)
  initial begin
    reset = 1'b1; start = 1'b0; ack = 1'b0; snooze = 1'b0;
    rom[0] = 28'h7002123;   // mask 111, interval 2, durations 1/2/3
    rom[1] = 28'h7000FFF;   // interval 0, left unacknowledged
    rom[2] = 28'h8000000;   // end marker
    rom[3] = 28'h0000000;

    // Phase A: reset state, full dispense, missed dose, end marker
    push(1,   2'd0, 28'h0000000, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0);
    push(6,   2'd0, 28'h7002123, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0);
    push(11,  2'd0, 28'h7002123, 1'b1, 3'b000, 12'h000, 1'b0, 4'd0);
    push(13,  2'd0, 28'h7002123, 1'b0, 3'b111, 12'h123, 1'b0, 4'd0);
    push(15,  2'd0, 28'h7002123, 1'b0, 3'b110, 12'h012, 1'b0, 4'd0);
    push(19,  2'd0, 28'h7002123, 1'b0, 3'b100, 12'h001, 1'b0, 4'd0);
    push(23,  2'd0, 28'h7002123, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0);
    push(25,  2'd1, 28'h7002123, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0);
    push(27,  2'd1, 28'h7000FFF, 1'b1, 3'b000, 12'h000, 1'b0, 4'd0);
    push(147, 2'd1, 28'h7000FFF, 1'b0, 3'b000, 12'h000, 1'b0, 4'd1);
    push(148, 2'd2, 28'h7000FFF, 1'b0, 3'b000, 12'h000, 1'b0, 4'd1);
    push(150, 2'd2, 28'h7000FFF, 1'b0, 3'b000, 12'h000, 1'b1, 4'd1);

    at(4);   reset = 1'b0; start = 1'b1;
    at(5);   start = 1'b0;
    at(13);  ack = 1'b1;
    at(14);  ack = 1'b0;

    // Phase B: restart from DONE, ack on the timeout tick, masked pills, wrap, reset
    at(152);
    rom[0] = 28'h1000123;   // mask 001: only pill1 dispenses
    rom[1] = 28'h0000000;
    rom[2] = 28'h0000000;
    rom[3] = 28'h0000000;
    start = 1'b1;
    push(152, 2'd0, 28'h7000FFF, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0);
    push(154, 2'd0, 28'h1000123, 1'b1, 3'b000, 12'h000, 1'b0, 4'd0);
    push(271, 2'd0, 28'h1000123, 1'b0, 3'b001, 12'h100, 1'b0, 4'd0);
    push(275, 2'd0, 28'h1000123, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0);
    push(277, 2'd1, 28'h1000123, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0);
    push(279, 2'd1, 28'h0000000, 1'b1, 3'b000, 12'h000, 1'b0, 4'd0);
    push(280, 2'd1, 28'h0000000, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0);
    push(282, 2'd2, 28'h0000000, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0);
    push(284, 2'd2, 28'h0000000, 1'b1, 3'b000, 12'h000, 1'b0, 4'd0);
    push(285, 2'd2, 28'h0000000, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0);
    push(287, 2'd3, 28'h0000000, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0);
    push(289, 2'd3, 28'h0000000, 1'b1, 3'b000, 12'h000, 1'b0, 4'd0);
    push(290, 2'd3, 28'h0000000, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0);
    push(292, 2'd0, 28'h0000000, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0);
    push(294, 2'd0, 28'h1000123, 1'b1, 3'b000, 12'h000, 1'b0, 4'd0);
    push(296, 2'd0, 28'h1000123, 1'b0, 3'b001, 12'h100, 1'b0, 4'd0);
    push(297, 2'd0, 28'h0000000, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0);

    at(153); start = 1'b0;
    at(160); snooze = 1'b1;   // no effect in the default build
    at(161); snooze = 1'b0;
    at(271); ack = 1'b1;      // same edge as the 30th timeout tick
    at(272); ack = 1'b0;
    at(280); ack = 1'b1;
    at(281); ack = 1'b0;
    at(285); ack = 1'b1;
    at(286); ack = 1'b0;
    at(290); ack = 1'b1;
    at(291); ack = 1'b0;
    at(296); ack = 1'b1;
    at(297); ack = 1'b0; reset = 1'b1;   // mid-DISPENSE reset
    at(298); reset = 1'b0;
    at(320);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_vectors actual=%0d pending required=0 next_cyc=%0d",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
